// File: rtl/layer_sequencer.sv
// layer_sequencer: drives one neural-network layer through an external
// non-linear unit. It optionally loads M biases, pulses nl_start, then feeds
// M*P matrix elements one at a time. Each activated result is forwarded on
// out_data. A watchdog per element flags err and drops back to IDLE.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           layer command handshake
//   cmd_act, cmd_load_bias        activation code, bias preload request
//   abort                         synchronous abort to IDLE
//   bias_valid/bias_ready/bias_data   bias stream (M entries)
//   in_valid/in_ready/in_data     matrix element stream
//   nl_*                          interface to the non-linear layer unit
//   out_valid/out_data            activated results (no backpressure)
//   busy/done/err                 status
module layer_sequencer #(
  parameter int unsigned M          = 3,
  parameter int unsigned P          = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_act,
  input  logic                      cmd_load_bias,
  input  logic                      abort,
  input  logic                      bias_valid,
  output logic                      bias_ready,
  input  logic [DATA_WIDTH-1:0]     bias_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*DATA_WIDTH-1:0]   in_data,
  output logic                      nl_start,
  output logic [1:0]                nl_activation_type,
  output logic [2*DATA_WIDTH-1:0]   nl_matrix_result,
  output logic                      nl_matrix_valid,
  output logic [DATA_WIDTH-1:0]     nl_bias_in,
  output logic                      nl_bias_wen,
  output logic [$clog2(M)-1:0]      nl_bias_addr,
  input  logic [2*DATA_WIDTH-1:0]   nl_app_result,
  input  logic                      nl_app_done,
  output logic                      out_valid,
  output logic [2*DATA_WIDTH-1:0]   out_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned RW  = 2 * DATA_WIDTH;
  localparam int unsigned AW  = $clog2(M);
  localparam int unsigned NEL = M * P;
  localparam int unsigned CW  = $clog2(M * P + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_BIAS, START, FEED, WAIT_RES, FINISH
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_elem_cnt, w_elem_cnt;
  logic [AW-1:0]   r_bias_idx, w_bias_idx;
  logic [TW-1:0]   r_wait_cnt, w_wait_cnt;

  logic            r_cmd_ready, w_cmd_ready;
  logic            r_bias_ready, w_bias_ready;
  logic            r_in_ready, w_in_ready;
  logic            r_start, w_start;
  logic [1:0]      r_act, w_act;
  logic [RW-1:0]   r_mat_res, w_mat_res;
  logic            r_mat_valid, w_mat_valid;
  logic [DATA_WIDTH-1:0] r_bias_in, w_bias_in;
  logic            r_bias_wen, w_bias_wen;
  logic [AW-1:0]   r_bias_addr, w_bias_addr;
  logic            r_out_valid, w_out_valid;
  logic [RW-1:0]   r_out_data, w_out_data;
  logic            r_busy, w_busy;
  logic            r_done, w_done;
  logic            r_err, w_err;

  // State, counters and all outputs are registered from their next values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_elem_cnt   <= '0;
      r_bias_idx   <= '0;
      r_wait_cnt   <= '0;
      r_cmd_ready  <= 1'b1;
      r_bias_ready <= 1'b0;
      r_in_ready   <= 1'b0;
      r_start      <= 1'b0;
      r_act        <= 2'b00;
      r_mat_res    <= '0;
      r_mat_valid  <= 1'b0;
      r_bias_in    <= '0;
      r_bias_wen   <= 1'b0;
      r_bias_addr  <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_elem_cnt   <= w_elem_cnt;
      r_bias_idx   <= w_bias_idx;
      r_wait_cnt   <= w_wait_cnt;
      r_cmd_ready  <= w_cmd_ready;
      r_bias_ready <= w_bias_ready;
      r_in_ready   <= w_in_ready;
      r_start      <= w_start;
      r_act        <= w_act;
      r_mat_res    <= w_mat_res;
      r_mat_valid  <= w_mat_valid;
      r_bias_in    <= w_bias_in;
      r_bias_wen   <= w_bias_wen;
      r_bias_addr  <= w_bias_addr;
      r_out_valid  <= w_out_valid;
      r_out_data   <= w_out_data;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_err        <= w_err;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state     = r_state;
    w_elem_cnt  = r_elem_cnt;
    w_bias_idx  = r_bias_idx;
    w_wait_cnt  = r_wait_cnt;
    w_act       = r_act;
    w_mat_res   = r_mat_res;
    w_bias_in   = r_bias_in;
    w_bias_addr = r_bias_addr;
    w_out_data  = r_out_data;
    w_err       = r_err;
    w_mat_valid = 1'b0;
    w_bias_wen  = 1'b0;
    w_out_valid = 1'b0;

    if (abort) begin
      w_state    = IDLE;
      w_elem_cnt = '0;
      w_bias_idx = '0;
      w_wait_cnt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            w_act      = cmd_act;
            w_elem_cnt = '0;
            w_bias_idx = '0;
            w_err      = 1'b0;
            w_state    = cmd_load_bias ? LOAD_BIAS : START;
          end
        end
        LOAD_BIAS: begin
          if (bias_valid) begin
            w_bias_wen  = 1'b1;
            w_bias_in   = bias_data;
            w_bias_addr = r_bias_idx;
            if (r_bias_idx == AW'(M - 1)) begin
              w_bias_idx = '0;
              w_state    = START;
            end else begin
              w_bias_idx = r_bias_idx + AW'(1);
            end
          end
        end
        START: w_state = FEED;
        FEED: begin
          if (in_valid) begin
            w_mat_res   = in_data;
            w_mat_valid = 1'b1;
            w_wait_cnt  = '0;
            w_state     = WAIT_RES;
          end
        end
        WAIT_RES: begin
          // Completion is checked first so a same-cycle timeout is not an error.
          if (nl_app_done) begin
            w_out_data  = nl_app_result;
            w_out_valid = 1'b1;
            w_elem_cnt  = r_elem_cnt + CW'(1);
            w_state     = (r_elem_cnt == CW'(NEL - 1)) ? FINISH : FEED;
          end else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
            w_err      = 1'b1;
            w_wait_cnt = '0;
            w_elem_cnt = '0;
            w_state    = IDLE;
          end else begin
            w_wait_cnt = r_wait_cnt + TW'(1);
          end
        end
        FINISH:  w_state = IDLE;
        default: w_state = IDLE;
      endcase
    end

    // State-decoded outputs are taken from the next state so they line up
    // with the state register.
    w_cmd_ready  = (w_state == IDLE);
    w_bias_ready = (w_state == LOAD_BIAS);
    w_in_ready   = (w_state == FEED);
    w_start      = (w_state == START);
    w_done       = (w_state == FINISH);
    w_busy       = (w_state != IDLE);
  end

  assign cmd_ready          = r_cmd_ready;
  assign bias_ready         = r_bias_ready;
  assign in_ready           = r_in_ready;
  assign nl_start           = r_start;
  assign nl_activation_type = r_act;
  assign nl_matrix_result   = r_mat_res;
  assign nl_matrix_valid    = r_mat_valid;
  assign nl_bias_in         = r_bias_in;
  assign nl_bias_wen        = r_bias_wen;
  assign nl_bias_addr       = r_bias_addr;
  assign out_valid          = r_out_valid;
  assign out_data           = r_out_data;
  assign busy               = r_busy;
  assign done               = r_done;
  assign err                = r_err;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: a responding non-linear unit model,
// transaction queues of expected bias writes / elements / results, and a
// per-cycle scoreboard on the falling edge.
module tb_layer_sequencer;

  localparam int unsigned M   = 3;
  localparam int unsigned P   = 3;
  localparam int unsigned DW  = 8;
  localparam int unsigned TO  = 64;
  localparam int unsigned RW  = 2 * DW;
  localparam int unsigned NEL = M * P;

  logic          clk;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_load_bias, abort;
  logic [1:0]    cmd_act;
  logic          bias_valid, bias_ready;
  logic [DW-1:0] bias_data;
  logic          in_valid, in_ready;
  logic [RW-1:0] in_data;
  logic          nl_start, nl_matrix_valid, nl_bias_wen, nl_app_done;
  logic [1:0]    nl_activation_type;
  logic [RW-1:0] nl_matrix_result, nl_app_result, out_data;
  logic [DW-1:0] nl_bias_in;
  logic [1:0]    nl_bias_addr;
  logic          out_valid, busy, done, err;

  layer_sequencer #(.M(M), .P(P), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_act(cmd_act),
    .cmd_load_bias(cmd_load_bias), .abort(abort),
    .bias_valid(bias_valid), .bias_ready(bias_ready), .bias_data(bias_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .nl_start(nl_start), .nl_activation_type(nl_activation_type),
    .nl_matrix_result(nl_matrix_result), .nl_matrix_valid(nl_matrix_valid),
    .nl_bias_in(nl_bias_in), .nl_bias_wen(nl_bias_wen), .nl_bias_addr(nl_bias_addr),
    .nl_app_result(nl_app_result), .nl_app_done(nl_app_done),
    .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [RW-1:0] exp_out_q[$];
  logic [RW-1:0] exp_mat_q[$];
  logic [9:0]    exp_bias_q[$];
  int            exp_done  = 0;
  int            exp_start = 0;
  logic [1:0]    exp_act   = 2'b00;
  logic          exp_err   = 1'b0;
  int            out_cnt   = 0;
  logic [RW-1:0] last_out  = '0;
  int            b_idx     = 0;

  int  resp_mode = 1;   // 1: answer every element, 0: never answer
  int  resp_lat  = 0;   // 0: random latency 1..4
  bit  resp_spur = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endfunction

  // Behaviour of the external non-linear unit for each activation code.
  function automatic logic [RW-1:0] nl_f(input logic [RW-1:0] x, input logic [1:0] a);
    case (a)
      2'b00:   return x[RW-1] ? '0 : x;
      2'b01:   return x;
      2'b10:   return RW'($signed(x) >>> 1);
      default: return ~x;
    endcase
  endfunction

  // Responding non-linear unit: answers each element after a latency,
  // optionally followed by one stray done pulse.
  initial begin : responder
    int            cnt;
    bit            spur_next;
    logic [RW-1:0] res;
    cnt = 0; spur_next = 1'b0; res = '0;
    nl_app_done = 1'b0; nl_app_result = '0;
    forever begin
      @(negedge clk);
      if (nl_matrix_valid && resp_mode == 1 && !rst) begin
        cnt = (resp_lat == 0) ? int'($urandom_range(1, 4)) : resp_lat;
        res = nl_f(nl_matrix_result, nl_activation_type);
      end
      @(posedge clk); #1;
      nl_app_done = 1'b0;
      if (spur_next) begin
        nl_app_done   = 1'b1;
        nl_app_result = 16'hDEAD;
        spur_next     = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          nl_app_done   = 1'b1;
          nl_app_result = res;
          spur_next     = resp_spur;
        end
      end
    end
  end

  // Per-cycle scoreboard.
  bit            outstanding = 1'b0;
  logic          prev_done   = 1'b0;
  always @(negedge clk) begin
    logic [RW-1:0] e;
    logic [9:0]    b;
    if (!rst) begin
      chk("cmd_ready_eq_not_busy", 32'(cmd_ready), 32'(!busy));
      chk("ready_exclusive", 32'(32'(cmd_ready) + 32'(bias_ready) + 32'(in_ready) <= 1), 32'd1);
      chk("err", 32'(err), 32'(exp_err));
      if (busy) chk("act_held", 32'(nl_activation_type), 32'(exp_act));
      if (prev_done) chk("busy_after_done", 32'(busy), 32'd0);
      if (nl_bias_wen) begin
        chk("bias_expected", 32'(exp_bias_q.size() > 0), 32'd1);
        if (exp_bias_q.size() > 0) begin
          b = exp_bias_q.pop_front();
          chk("bias_addr", 32'(nl_bias_addr), 32'(b[9:8]));
          chk("bias_data", 32'(nl_bias_in), 32'(b[7:0]));
        end
      end
      if (nl_start) begin
        chk("start_expected", 32'(exp_start > 0), 32'd1);
        chk("start_after_biases", 32'(exp_bias_q.size()), 32'd0);
        if (exp_start > 0) exp_start--;
      end
      if (done) begin
        chk("done_expected", 32'(exp_done > 0), 32'd1);
        if (exp_done > 0) exp_done--;
      end
      if (nl_matrix_valid) begin
        chk("one_outstanding", 32'(outstanding), 32'd0);
        outstanding = 1'b1;
        chk("mat_expected", 32'(exp_mat_q.size() > 0), 32'd1);
        if (exp_mat_q.size() > 0) begin
          e = exp_mat_q.pop_front();
          chk("mat_data", 32'(nl_matrix_result), 32'(e));
        end
      end
      if (out_valid) begin
        outstanding = 1'b0;
        out_cnt++;
        last_out = out_data;
        chk("out_expected", 32'(exp_out_q.size() > 0), 32'd1);
        if (exp_out_q.size() > 0) begin
          e = exp_out_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e));
        end
      end
      if (!busy) outstanding = 1'b0;
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic wait_ready(input int which, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = cmd_ready;
        1:       seen = bias_ready;
        default: seen = in_ready;
      endcase
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = !busy;
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  task automatic send_cmd(input logic [1:0] act, input bit lb);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_act = act; cmd_load_bias = lb;
    wait_ready(0, "cmd_accept");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_act = act; exp_err = 1'b0; out_cnt = 0; b_idx = 0;
    if (!lb) exp_start++;
  endtask

  task automatic send_bias(input logic [DW-1:0] d, input logic [DW-1:0] want);
    @(posedge clk); #1;
    bias_valid = 1'b1; bias_data = d;
    wait_ready(1, "bias_accept");
    @(posedge clk); #1;
    bias_valid = 1'b0;
    exp_bias_q.push_back({2'(b_idx), want});
    b_idx++;
    if (b_idx == M) exp_start++;
  endtask

  task automatic send_elem(input logic [RW-1:0] d, input bit push_out, input bit hold);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d;
    wait_ready(2, "elem_accept");
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
    exp_mat_q.push_back(d);
    if (push_out) exp_out_q.push_back(nl_f(d, exp_act));
  endtask

  task automatic run_elems(input bit hold, input int gap_max, input logic [RW-1:0] last_el);
    logic [RW-1:0] d;
    for (int e = 0; e < NEL; e++) begin
      d = (e == NEL - 1) ? last_el : RW'($urandom);
      if (!hold && gap_max > 0) repeat ($urandom_range(0, gap_max)) @(posedge clk);
      send_elem(d, 1'b1, hold && (e != NEL - 1));
    end
    exp_done++;
    wait_idle("layer_idle");
    chk("layer_out_count", 32'(out_cnt), 32'(NEL));
    chk("layer_done_seen", 32'(exp_done), 32'd0);
    chk("layer_out_drained", 32'(exp_out_q.size()), 32'd0);
  endtask

  task automatic rand_biases();
    logic [DW-1:0] r;
    for (int i = 0; i < M; i++) begin
      r = DW'($urandom);
      send_bias(r, r);
    end
  endtask

  initial begin : main
    logic [1:0] a;
    bit         lb;
    rst = 1'b1; cmd_valid = 1'b0; cmd_act = 2'b00; cmd_load_bias = 1'b0; abort = 1'b0;
    bias_valid = 1'b0; bias_data = '0; in_valid = 1'b0; in_data = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_start", 32'(nl_start), 32'd0);
    chk("rst_act", 32'(nl_activation_type), 32'd0);
    chk("rst_bias_wen", 32'(nl_bias_wen), 32'd0);
    chk("rst_bias_addr", 32'(nl_bias_addr), 32'd0);
    chk("rst_mat_valid", 32'(nl_matrix_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Bias load with fixed values, then a full linear layer
    send_cmd(2'b01, 1'b1);
    send_bias(8'd5, 8'h05);
    send_bias(8'(-3), 8'hFD);
    send_bias(8'd7, 8'h07);
    run_elems(1'b0, 2, 16'h1234);
    chk("bias_layer_last", 32'(last_out), 32'h1234);

    // ReLU layer, unit answers 2 cycles after each element
    resp_lat = 2;
    send_cmd(2'b00, 1'b0);
    run_elems(1'b0, 1, 16'hFF80);
    chk("relu_neg_last", 32'(last_out), 32'h0000);
    resp_lat = 0;

    // Linear passthrough of a negative value
    send_cmd(2'b01, 1'b0);
    run_elems(1'b0, 1, 16'hFF80);
    chk("linear_last", 32'(last_out), 32'hFF80);

    // Random layers
    for (int it = 0; it < 4; it++) begin
      a  = 2'($urandom);
      lb = 1'($urandom);
      send_cmd(a, lb);
      if (lb) rand_biases();
      run_elems(1'b0, 3, RW'($urandom));
    end

    // Stray done pulses in FEED with in_valid held high
    resp_spur = 1'b1;
    send_cmd(2'b10, 1'b1);
    rand_biases();
    run_elems(1'b1, 0, 16'h0100);
    chk("spur_last", 32'(last_out), 32'h0080);
    resp_spur = 1'b0;

    // Abort after four elements, then a full restarted layer
    send_cmd(2'b11, 1'b0);
    for (int e = 0; e < 4; e++) send_elem(RW'($urandom), 1'b1, 1'b0);
    wait_ready(2, "abort_in_feed");
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_out_count", 32'(out_cnt), 32'd4);
    @(posedge clk); #1; in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1; in_valid = 1'b0;
    send_cmd(2'b11, 1'b0);
    run_elems(1'b0, 1, 16'h00FF);
    chk("restart_last", 32'(last_out), 32'hFF00);

    // Timeout: the unit never answers
    resp_mode = 0;
    send_cmd(2'b01, 1'b0);
    send_elem(16'h0042, 1'b0, 1'b0);
    for (int k = 0; k <= TO; k++) begin
      if (k == TO) begin #1; exp_err = 1'b1; end
      @(negedge clk);
      if (k == 0)      chk("to_mat_valid", 32'(nl_matrix_valid), 32'd1);
      if (k == TO - 1) chk("to_busy_before", 32'(busy), 32'd1);
      if (k == TO) begin
        chk("to_err", 32'(err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_cmd_ready", 32'(cmd_ready), 32'd1);
      end
    end
    repeat (3) @(negedge clk);
    chk("to_no_out", 32'(out_cnt), 32'd0);

    // Abort wins over cmd_valid in IDLE and leaves err alone
    @(posedge clk); #1; abort = 1'b1; cmd_valid = 1'b1; cmd_act = 2'b10;
    @(posedge clk); #1; abort = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_cmd_busy", 32'(busy), 32'd0);
    chk("abort_keeps_err", 32'(err), 32'd1);

    // Reset clears the sticky error
    @(posedge clk); #1; rst = 1'b1; exp_err = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst2_err", 32'(err), 32'd0);
    chk("rst2_act", 32'(nl_activation_type), 32'd0);
    chk("rst2_cmd_ready", 32'(cmd_ready), 32'd1);

    // Reset while waiting on a result
    send_cmd(2'b11, 1'b0);
    send_elem(16'h7777, 1'b0, 1'b0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst3_busy", 32'(busy), 32'd0);
    chk("rst3_act", 32'(nl_activation_type), 32'd0);
    chk("rst3_mat_res", 32'(nl_matrix_result), 32'd0);
    chk("rst3_cmd_ready", 32'(cmd_ready), 32'd1);

    // Normal operation afterwards
    resp_mode = 1;
    send_cmd(2'b00, 1'b1);
    rand_biases();
    run_elems(1'b0, 2, 16'h0011);
    chk("final_last", 32'(last_out), 32'h0011);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- M, 3, output rows
- P, 3, output columns; one layer = M*P elements
- DATA_WIDTH, 8, operand width; results are 2*DATA_WIDTH
- TIMEOUT, 64, cycles allowed per element
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock, rising edge
- rst, in, 1, synchronous active-high reset
- cmd_valid/cmd_ready, in/out, 1/1, layer command handshake
- cmd_act, in, 2, activation code
- cmd_load_bias, in, 1, 1 = load M biases before the layer
- abort, in, 1, synchronous abort
- bias_valid/bias_ready, in/out, 1/1, bias stream handshake
- bias_data, in, DATA_WIDTH, signed bias
- in_valid/in_ready, in/out, 1/1, matrix element handshake
- in_data, in, 2*DATA_WIDTH, matrix element
- nl_start, out, 1, layer start pulse
- nl_activation_type, out, 2, held activation code
- nl_matrix_result, out, 2*DATA_WIDTH, element to layer
- nl_matrix_valid, out, 1, element strobe
- nl_bias_in, out, DATA_WIDTH, bias write data
- nl_bias_wen, out, 1, bias write enable
- nl_bias_addr, out, $clog2(M), bias write address
- nl_app_result, in, 2*DATA_WIDTH, activated result
- nl_app_done, in, 1, element completion
- out_valid, out, 1, result strobe (no backpressure)
- out_data, out, 2*DATA_WIDTH, result
- busy/done/err, out, 1/1/1, status

Function
REQ-003 SHALL be an FSM with states IDLE, LOAD_BIAS, START, FEED, WAIT_RES, FINISH; all outputs registered.
REQ-004 IDLE: cmd_ready=1. On cmd_valid, SHALL latch cmd_act into nl_activation_type, clear the element counter and err, then go to LOAD_BIAS if cmd_load_bias=1, else START.
REQ-005 LOAD_BIAS: bias_ready=1. Each accepted bias SHALL produce nl_bias_wen=1 for exactly one cycle on the following cycle, with nl_bias_in=bias_data and nl_bias_addr=0,1,...,M-1 in acceptance order. After the Mth acceptance, SHALL go to START.
REQ-006 START: SHALL assert nl_start for exactly one cycle, then go to FEED.
REQ-007 FEED: in_ready=1. On in_valid, SHALL register in_data onto nl_matrix_result, pulse nl_matrix_valid for one cycle on the next cycle, and go to WAIT_RES; at most one element outstanding.
REQ-008 WAIT_RES: on nl_app_done=1, SHALL sample nl_app_result and present it on out_data with out_valid=1 for one cycle on the next cycle. It then SHALL increment the element counter and go to FEED, or go to FINISH if this was element M*P-1.
REQ-009 WAIT_RES timeout: a cycle counter reset on entry SHALL, on reaching TIMEOUT without nl_app_done, set err=1 (sticky until the next accepted cmd) and return to IDLE without asserting done.
REQ-010 FINISH: SHALL pulse done for one cycle, then go to IDLE.
REQ-011 busy SHALL be 1 in every state except IDLE.
REQ-012 nl_app_done outside WAIT_RES SHALL be ignored; nl_app_done and timeout in the same cycle SHALL count as completion, not error.
REQ-013 abort=1 in any state SHALL go to IDLE next cycle, clear counters, pulse no done, leave err unchanged, and deassert all strobes. abort SHALL take precedence over cmd_valid in IDLE.
REQ-014 Ready signals (cmd_ready, bias_ready, in_ready) SHALL be asserted only in their own state, so a transfer is accepted exactly once.
REQ-015 The element counter SHALL be $clog2(M*P+1) bits wide and SHALL NOT wrap within a layer.

Reset
REQ-016 While rst=1 at a clock edge, SHALL enter IDLE and clear every output to 0 (nl_activation_type=2'b00, addresses and data 0, err=0), except cmd_ready=1 from the first cycle after reset.
REQ-017 rst mid-operation SHALL behave as abort and additionally clear err.

Verification
REQ-018 Bias load: cmd_load_bias=1, biases 5, -3, 7 -> nl_bias_wen pulses with addr 0/1/2 and data 8'h05/8'hFD/8'h07, followed by one nl_start pulse.
REQ-019 ReLU layer: cmd_act=00, 9 elements, model returns done 2 cycles after each nl_matrix_valid -> 9 out_valid pulses in order, then done=1 once and busy falling to 0.
REQ-020 Linear passthrough: element 16'hFF80 with model echoing it -> out_data=16'hFF80 and no activation change mid-layer.
REQ-021 Timeout: model never asserts nl_app_done, TIMEOUT=64 -> err=1 after 64 WAIT_RES cycles, return to IDLE, done never asserted.
REQ-022 Abort after 4 elements -> IDLE next cycle, no further nl_matrix_valid, next cmd restarts counting at element 0.
REQ-023 Spurious nl_app_done in FEED plus in_valid held high -> no extra out_valid, exactly one element accepted per WAIT_RES round trip.
